// File: rtl/led_matrix_scan_driver.sv
// Double-buffered 8x8 LED frame store, scanned one column at a time with a blanking gap before each column.
// Latency: all outputs registered; a swapped-in frame is first shown from column 0 of the scan after the frame boundary.
// Backpressure: wr_ready drops after a wr_last handshake and returns high when the swap happens at the next frame boundary.
module led_matrix_scan_driver #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic [7:0] col_sel_n,
  output logic [7:0] row_data,
  output logic       frame_start,
  output logic       swap_done
);

  // One phase counter serves both states, so size it for the longer of the two.
  localparam int PMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t               state;
  logic [PW-1:0]        phase;
  logic [2:0]           col;
  logic                 front;    // bank currently being displayed
  logic                 pending;  // a complete frame sits in the back bank awaiting a swap
  logic [1:0][7:0][7:0] banks;    // banks[bank][column] = row bits

  logic wr_fire;
  assign wr_fire = wr_valid && wr_ready;

  // Writes only ever target the back bank; the displayed bank is read-only here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      banks <= '0;
    end else if (wr_fire) begin
      banks[~front][wr_col] <= wr_data;
    end
  end

  // Scan FSM with registered outputs, plus the swap/pending handshake tied to the frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BLANK;
      phase       <= '0;
      col         <= 3'd0;
      front       <= 1'b0;
      pending     <= 1'b0;
      wr_ready    <= 1'b1;
      col_sel_n   <= 8'hFF;
      row_data    <= 8'h00;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
      case (state)
        ST_BLANK: begin
          col_sel_n <= 8'hFF;
          row_data  <= 8'h00;
          if (phase == BLANK_LAST) begin
            state <= ST_ON;
            phase <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_ON: begin
          col_sel_n   <= ~(8'h01 << col);
          row_data    <= banks[front][col];
          frame_start <= (col == 3'd0) && (phase == '0);
          if (phase == DWELL_LAST) begin
            state <= ST_BLANK;
            phase <= '0;
            col   <= col + 3'd1;
            // Only a frame that was already pending before this boundary is swapped in;
            // a wr_last landing on the boundary itself waits a full frame.
            if ((col == 3'd7) && pending) begin
              front     <= ~front;
              pending   <= 1'b0;
              wr_ready  <= 1'b1;
              swap_done <= 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: begin
          state <= ST_BLANK;
          phase <= '0;
        end
      endcase
      // wr_fire implies pending was clear, so this never collides with the swap above.
      if (wr_fire && wr_last) begin
        pending  <= 1'b1;
        wr_ready <= 1'b0;
      end
    end
  end

endmodule
